sync_fifo_multimode: RTL and testbench
======================================

Name: sync_fifo_multimode

Overview:
- Single-clock successor to the dual-clock general FIFO, for buffering inside one clock domain. Gray-code pointer crossing is not needed.
- Adds, selectable by parameter:
  - standard or first-word-fall-through (FWFT) read mode
  - programmable almost-full and almost-empty thresholds
  - a full-range occupancy count
  - sticky overflow/underflow error flags
- Sits between a packet producer and consumer in the same clock domain. It replaces ad-hoc skid buffers.

Parameters:
- DWIDTH, 32, data word width in bits.
- AWIDTH, 9, address width; capacity is 2**AWIDTH words.
- ALMOST_FULL_THOLD, 500, almost_full asserts when depth >= this value.
- ALMOST_EMPTY_THOLD, 4, almost_empty asserts when depth <= this value.
- FIRST_WORD_FALL_THRU, 0, 0 = standard read (data one cycle after read_enable); 1 = FWFT (head word presented while empty is low).

Ports:
- clock, input, 1, single clock; all logic on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- fifo_flush, input, 1, synchronous flush; empties the FIFO and clears the error flags.
- write_enable, input, 1, push write_data when not full.
- write_data, input, DWIDTH, data to push.
- read_enable, input, 1, pop request.
- read_data, output, DWIDTH, output word (registered).
- full, output, 1, depth == 2**AWIDTH.
- empty, output, 1, no word is available to read.
- almost_full, output, 1, depth >= ALMOST_FULL_THOLD.
- almost_empty, output, 1, depth <= ALMOST_EMPTY_THOLD.
- depth, output, AWIDTH+1, words held (0 .. 2**AWIDTH).
- overflow, output, 1, sticky: a write was attempted while full.
- underflow, output, 1, sticky: a read was attempted while empty.

Behaviour:
- Reset (asynchronous assert):
  - pointers and depth go to 0
  - empty=1, almost_empty=1, full=0, almost_full=0
  - overflow=0, underflow=0, read_data=0
  - RAM contents are not cleared.
- Acceptance is decided on the flag values before the edge:
  - A write is accepted iff write_enable && !full.
  - A read is accepted iff read_enable && !empty.
  - There is no pass-through: a write while full is dropped even if a read occurs in the same cycle.
- Depth and flags:
  - Accepted write only: depth+1. Accepted read only: depth-1. Both accepted: depth unchanged.
  - Pointers are AWIDTH bits and wrap modulo 2**AWIDTH. depth is the single source of truth for full.
  - All flags are registered and update on the same edge as depth.
- Standard mode (FIRST_WORD_FALL_THRU=0):
  - On an accepted read at edge N, read_data holds the head word after edge N; the latency is 1 cycle.
  - read_data holds its value otherwise.
  - empty = (depth == 0). A write at edge N clears empty after edge N.
- FWFT mode (FIRST_WORD_FALL_THRU=1):
  - The head word is loaded into an output register. empty is low only while read_data holds a valid head word.
  - First write into an empty FIFO at edge N: read_data is valid and empty=0 after edge N+1 (two-cycle write-to-visible latency).
  - Accepted read at edge N: after edge N, read_data shows the next word if one exists; otherwise empty=1.
  - Back-to-back reads sustain 1 word per cycle.
  - depth counts the word in the output register.
- Error flags:
  - overflow sets on write_enable && full.
  - underflow sets on read_enable && empty.
  - Both hold until fifo_flush or reset.
- fifo_flush:
  - Has priority over a same-cycle write or read; neither is accepted.
  - After the edge: depth=0, empty=1, error flags cleared, FWFT output register invalidated. read_data keeps its value.
- Reset asserted mid-operation behaves exactly as at power-up. Reset deassertion is expected synchronous to clock.

Optional Feature:
- FIFO_PARITY_EN:
  - When defined, each RAM word stores an extra even-parity bit computed on write_data.
  - An output port parity_error (1 bit) pulses high for one cycle when the word loaded into read_data fails the parity check.
  - When undefined, the RAM is DWIDTH wide and the parity_error port does not exist.

Test Plan:
- Reset, then write 0x11,0x22,0x33 with standard mode -> three reads return 0x11,0x22,0x33 each one cycle after read_enable; depth goes 3,2,1,0; empty=1 at end.
- AWIDTH=4: fill with 16 writes -> full=1, depth=16. A 17th write (0xFF) -> overflow=1, data dropped. Drain all 16 -> values match; no 0xFF appears.
- ALMOST_FULL_THOLD=12, ALMOST_EMPTY_THOLD=2: write 12 words -> almost_full rises on the 12th write edge. Read down to 2 -> almost_empty rises when depth=2.
- FWFT=1: single write 0xA5 into an empty FIFO -> read_data=0xA5 and empty=0 two edges later. read_enable held 1 cycle -> empty=1 next cycle. A further read_enable -> underflow=1.
- Simultaneous write+read at depth 5 for 100 cycles with pointer wrap -> depth stays 5 and the data order is preserved.
- Assert fifo_flush together with write_enable at depth 7 with overflow set -> depth=0, empty=1, overflow=0, and the write is discarded. Async reset mid-burst -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/sync_fifo_multimode.sv
// sync_fifo_multimode: single-clock FIFO with standard or first-word-fall-through
// read mode, almost-full/almost-empty thresholds, occupancy count and sticky
// overflow/underflow flags.
// Optional build macro FIFO_PARITY_EN: stores an even-parity bit per RAM word and
// adds a parity_error output that pulses when a word loaded into read_data fails.
module sync_fifo_multimode #(
    parameter int DWIDTH               = 32,
    parameter int AWIDTH               = 9,
    parameter int ALMOST_FULL_THOLD    = 500,
    parameter int ALMOST_EMPTY_THOLD   = 4,
    parameter int FIRST_WORD_FALL_THRU = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_flush,
    input  logic              write_enable,
    input  logic [DWIDTH-1:0] write_data,
    input  logic              read_enable,
    output logic [DWIDTH-1:0] read_data,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   depth,
    output logic              overflow,
    output logic              underflow
`ifdef FIFO_PARITY_EN
    ,
    output logic              parity_error
`endif
);

    localparam int DEPTH_W = AWIDTH + 1;
    localparam int CAP_INT = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] CAPACITY = DEPTH_W'(CAP_INT);
`ifdef FIFO_PARITY_EN
    localparam int MW = DWIDTH + 1;
`else
    localparam int MW = DWIDTH;
`endif

    logic [MW-1:0] mem [0:CAP_INT-1];

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [AWIDTH:0]   depth_q, depth_d;
    logic [DWIDTH-1:0] read_data_q, read_data_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              almost_full_q, almost_full_d;
    logic              almost_empty_q, almost_empty_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;
`ifdef FIFO_PARITY_EN
    logic              parity_error_q, parity_error_d;
`endif

    logic              wr_acc;
    logic              rd_acc;
    logic              load;
    logic [AWIDTH:0]   ram_cnt;
    logic [MW-1:0]     mem_rword;
    logic [MW-1:0]     mem_wword;

    // Acceptance, pointer/depth bookkeeping, output register load and flag update.
    always_comb begin
        wr_acc    = write_enable && !full_q && !fifo_flush;
        rd_acc    = read_enable && !empty_q && !fifo_flush;
        // In FWFT mode the output register holds one of the counted words.
        ram_cnt   = depth_q - {{AWIDTH{1'b0}}, valid_q};
        mem_rword = mem[rd_ptr_q];
`ifdef FIFO_PARITY_EN
        mem_wword = {^write_data, write_data};
`else
        mem_wword = write_data;
`endif

        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        depth_d       = depth_q;
        read_data_d   = read_data_q;
        valid_d       = 1'b0;
        overflow_d    = overflow_q | (write_enable & full_q);
        underflow_d   = underflow_q | (read_enable & empty_q);

        if (FIRST_WORD_FALL_THRU != 0) begin
            // Refill the output register whenever it is free or being consumed.
            load = !fifo_flush && (ram_cnt != '0) && (!valid_q || rd_acc);
            if (load)
                valid_d = 1'b1;
            else if (rd_acc)
                valid_d = 1'b0;
            else
                valid_d = valid_q;
        end else begin
            load = rd_acc;
        end

        if (wr_acc)
            wr_ptr_d = wr_ptr_q + AWIDTH'(1);
        if (load) begin
            rd_ptr_d    = rd_ptr_q + AWIDTH'(1);
            read_data_d = mem_rword[DWIDTH-1:0];
        end

        if (wr_acc && !rd_acc)
            depth_d = depth_q + DEPTH_W'(1);
        else if (rd_acc && !wr_acc)
            depth_d = depth_q - DEPTH_W'(1);

`ifdef FIFO_PARITY_EN
        // Even parity: data plus stored bit must XOR to zero.
        parity_error_d = load && (^mem_rword);
`endif

        if (fifo_flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            depth_d     = '0;
            valid_d     = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        full_d         = (depth_d == CAPACITY);
        almost_full_d  = (32'(depth_d) >= ALMOST_FULL_THOLD);
        almost_empty_d = (32'(depth_d) <= ALMOST_EMPTY_THOLD);
        if (FIRST_WORD_FALL_THRU != 0)
            empty_d = !valid_d;
        else
            empty_d = (depth_d == '0);
    end

    // Storage array; contents intentionally survive reset.
    always_ff @(posedge clock) begin
        if (wr_acc)
            mem[wr_ptr_q] <= mem_wword;
    end

    // State and flag registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            depth_q        <= '0;
            read_data_q    <= '0;
            valid_q        <= 1'b0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
`ifdef FIFO_PARITY_EN
            parity_error_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            depth_q        <= depth_d;
            read_data_q    <= read_data_d;
            valid_q        <= valid_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
`ifdef FIFO_PARITY_EN
            parity_error_q <= parity_error_d;
`endif
        end
    end

    assign read_data    = read_data_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign depth        = depth_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
`ifdef FIFO_PARITY_EN
    assign parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_sync_fifo_multimode.sv
// Directed bench for sync_fifo_multimode: one standard-mode instance (AWIDTH=4,
// thresholds 12/2) and one FWFT instance (AWIDTH=4), sharing clock and reset.
module tb_sync_fifo_multimode;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       a_flush, a_we, a_re;
    logic [7:0] a_wd, a_rd;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
    logic [4:0] a_depth;

    logic       b_flush, b_we, b_re;
    logic [7:0] b_wd, b_rd;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
    logic [4:0] b_depth;

`ifdef FIFO_PARITY_EN
    logic a_pe, b_pe;
`endif

    sync_fifo_multimode #(
        .DWIDTH(8), .AWIDTH(4), .ALMOST_FULL_THOLD(12),
        .ALMOST_EMPTY_THOLD(2), .FIRST_WORD_FALL_THRU(0)
    ) dut_std (
        .clock(clock), .reset(reset), .fifo_flush(a_flush),
        .write_enable(a_we), .write_data(a_wd), .read_enable(a_re),
        .read_data(a_rd), .full(a_full), .empty(a_empty),
        .almost_full(a_af), .almost_empty(a_ae), .depth(a_depth),
        .overflow(a_ovf), .underflow(a_udf)
`ifdef FIFO_PARITY_EN
        , .parity_error(a_pe)
`endif
    );

    sync_fifo_multimode #(
        .DWIDTH(8), .AWIDTH(4), .ALMOST_FULL_THOLD(14),
        .ALMOST_EMPTY_THOLD(4), .FIRST_WORD_FALL_THRU(1)
    ) dut_fwft (
        .clock(clock), .reset(reset), .fifo_flush(b_flush),
        .write_enable(b_we), .write_data(b_wd), .read_enable(b_re),
        .read_data(b_rd), .full(b_full), .empty(b_empty),
        .almost_full(b_af), .almost_empty(b_ae), .depth(b_depth),
        .overflow(b_ovf), .underflow(b_udf)
`ifdef FIFO_PARITY_EN
        , .parity_error(b_pe)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    logic [7:0] vals [3];
    logic [7:0] wv, rv;

    initial begin
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
        a_flush = 0; a_we = 0; a_re = 0; a_wd = '0;
        b_flush = 0; b_we = 0; b_re = 0; b_wd = '0;

        #12;
        chk("rst_empty", a_empty, 1);
        chk("rst_ae", a_ae, 1);
        chk("rst_full", a_full, 0);
        chk("rst_af", a_af, 0);
        chk("rst_depth", a_depth, 0);
        chk("rst_ovf", a_ovf, 0);
        chk("rst_udf", a_udf, 0);
        chk("rst_rd", a_rd, 0);
        chk("rst_b_empty", b_empty, 1);
        @(posedge clock); #1;
        reset = 0;

        // Three words, standard mode, one-cycle read latency.
        for (int i = 0; i < 3; i++) begin
            a_we = 1; a_wd = vals[i];
            tick;
            chk("wr3_depth", a_depth, 32'(i + 1));
            chk("wr3_empty", a_empty, 0);
        end
        a_we = 0;
        a_re = 1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rd3_data", a_rd, vals[i]);
            chk("rd3_depth", a_depth, 32'(2 - i));
        end
        a_re = 0;
        chk("rd3_empty", a_empty, 1);

        // Fill to capacity, overflow attempt, drain.
        for (int i = 0; i < 16; i++) begin
            a_we = 1; a_wd = 8'(8'h40 + i);
            tick;
            chk("fill_af", a_af, (i + 1 >= 12) ? 1 : 0);
            chk("fill_full", a_full, (i == 15) ? 1 : 0);
        end
        chk("fill_depth", a_depth, 16);
        a_wd = 8'hFF;
        tick;
        a_we = 0;
        chk("ovf_set", a_ovf, 1);
        chk("ovf_depth", a_depth, 16);
        a_re = 1;
        for (int i = 0; i < 16; i++) begin
            tick;
            chk("drain_data", a_rd, 32'(8'h40 + i));
            chk("drain_ae", a_ae, (15 - i <= 2) ? 1 : 0);
            chk("drain_af", a_af, (15 - i >= 12) ? 1 : 0);
        end
        chk("drain_empty", a_empty, 1);
        tick;
        a_re = 0;
        chk("udf_set", a_udf, 1);
        chk("udf_rd_hold", a_rd, 8'h4F);
        chk("ovf_sticky", a_ovf, 1);

        // Flush with a same-cycle write at depth 7.
        for (int i = 0; i < 7; i++) begin
            a_we = 1; a_wd = 8'(8'h60 + i);
            tick;
        end
        chk("pre_flush_depth", a_depth, 7);
        a_flush = 1; a_we = 1; a_wd = 8'hEE;
        tick;
        a_flush = 0; a_we = 0;
        chk("flush_depth", a_depth, 0);
        chk("flush_empty", a_empty, 1);
        chk("flush_ovf", a_ovf, 0);
        chk("flush_udf", a_udf, 0);
        chk("flush_rd_hold", a_rd, 8'h4F);
        a_we = 1; a_wd = 8'h99;
        tick;
        a_we = 0; a_re = 1;
        tick;
        a_re = 0;
        chk("post_flush_data", a_rd, 8'h99);
        chk("post_flush_empty", a_empty, 1);

        // Steady write+read at depth 5 with pointer wrap.
        wv = 8'h80; rv = 8'h80;
        for (int i = 0; i < 5; i++) begin
            a_we = 1; a_wd = wv; wv++;
            tick;
        end
        a_re = 1;
        for (int i = 0; i < 100; i++) begin
            a_wd = wv; wv++;
            tick;
            chk("wrap_data", a_rd, rv); rv++;
            chk("wrap_depth", a_depth, 5);
        end
        a_re = 0;

        // Async reset in the middle of a burst.
        tick;
        @(posedge clock); #3;
        reset = 1;
        #1;
        chk("arst_depth", a_depth, 0);
        chk("arst_empty", a_empty, 1);
        chk("arst_ae", a_ae, 1);
        chk("arst_full", a_full, 0);
        chk("arst_rd", a_rd, 0);
        a_we = 0;
        @(posedge clock); #1;
        reset = 0;

        // FWFT: two-edge write-to-visible latency.
        b_we = 1; b_wd = 8'hA5;
        tick;
        b_we = 0;
        chk("fw_empty_n", b_empty, 1);
        chk("fw_depth_n", b_depth, 1);
        tick;
        chk("fw_empty_n1", b_empty, 0);
        chk("fw_rd_n1", b_rd, 8'hA5);
        b_re = 1;
        tick;
        b_re = 0;
        chk("fw_rd_empty", b_empty, 1);
        chk("fw_rd_depth", b_depth, 0);
        chk("fw_udf_clear", b_udf, 0);
        b_re = 1;
        tick;
        b_re = 0;
        chk("fw_udf_set", b_udf, 1);

        // FWFT back-to-back reads.
        for (int i = 1; i <= 3; i++) begin
            b_we = 1; b_wd = 8'(i);
            tick;
        end
        b_we = 0;
        tick;
        chk("fw_head", b_rd, 8'h01);
        chk("fw_depth3", b_depth, 3);
        b_re = 1;
        tick;
        chk("fw_b2b_1", b_rd, 8'h02);
        chk("fw_b2b_1e", b_empty, 0);
        tick;
        chk("fw_b2b_2", b_rd, 8'h03);
        chk("fw_b2b_2e", b_empty, 0);
        tick;
        b_re = 0;
        chk("fw_b2b_end", b_empty, 1);
        chk("fw_b2b_depth", b_depth, 0);

        // FWFT flush invalidates the output register but keeps read_data.
        b_we = 1; b_wd = 8'h77;
        tick;
        b_we = 0;
        tick;
        chk("fw_pre_flush", b_rd, 8'h77);
        b_flush = 1;
        tick;
        b_flush = 0;
        chk("fw_flush_empty", b_empty, 1);
        chk("fw_flush_depth", b_depth, 0);
        chk("fw_flush_udf", b_udf, 0);
        chk("fw_flush_rd", b_rd, 8'h77);
        tick;
        chk("fw_flush_stay", b_empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
